// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int LAT_DEFAULT = 2;
    // Wide enough for the largest legal latency (15).
    localparam int CNT_W       = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Latency down-counter: loads the access latency on a grant and counts down while busy.
module arb_lat_counter
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM data accesses onto one fixed-latency single-port RAM.
// Define ARB_RR_EN for round-robin arbitration; otherwise data always wins over fetch.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int LAT    = LAT_DEFAULT,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_pick_d;
    logic              w_zero;
    logic              r_ram_en;
    logic              r_ram_we;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

`ifdef ARB_RR_EN
    // Set when data took the last grant; resets to "fetch" so data wins first.
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
        end
    end

    assign w_pick_d = mem_req & (~if_req | ~r_last_d);
`else
    assign w_pick_d = mem_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = BUSY_D;
                end else if (if_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = BUSY_I;
                end
            end
            BUSY_I: begin
                if (w_zero) begin
                    if_done     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                if (w_zero) begin
                    mem_done    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    arb_lat_counter u_lat_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (w_grant_i | w_grant_d),
        .dec   (r_state != IDLE),
        .value (CNT_W'(LAT)),
        .zero  (w_zero)
    );

    // Request fields are captured at grant so the RAM sees them stable for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_ram_en <= w_grant_i | w_grant_d;
            r_ram_we <= w_grant_d & mem_we;
            if (w_grant_d) begin
                r_we    <= mem_we;
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
            end else if (w_grant_i) begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    assign if_rdata  = !if_done ? 32'h0 : (r_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0]);
    assign mem_rdata = (mem_done && !r_we) ? ram_rdata : '0;

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-schedule model.
// Honours ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, mem_req, mem_we;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata, ram_rdata;
    logic          if_done, mem_done, stall_if, stall_mem, ram_en, ram_we;
    logic [31:0]   if_rdata;
    logic [DW-1:0] mem_rdata, ram_wdata;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 0;

    // Model: each grant at edge N schedules ram_en at cycle N+1, done at N+1+LAT,
    // and the port is free again for a grant at edge N+LAT+2.
    int          en_cyc = -1, done_cyc = -1, free_edge = 0;
    bit          m_own_d, m_we, last_d;
    logic [63:0] m_addr, m_wdata;

    int last_idone = -1, last_mdone = -1, n_mdone = 0;
    bit dut_seq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit          e_en, e_id, e_md;
        logic [63:0] e_ir, e_mr;
        e_en = (cyc == en_cyc);
        e_id = (cyc == done_cyc) && !m_own_d;
        e_md = (cyc == done_cyc) && m_own_d;
        e_ir = !e_id ? 64'h0 : (m_addr[2] ? {32'h0, ram_rdata[63:32]} : {32'h0, ram_rdata[31:0]});
        e_mr = (e_md && !m_we) ? ram_rdata : 64'h0;
        chk("ram_en",    64'(ram_en),    64'(e_en));
        chk("ram_we",    64'(ram_we),    64'(e_en && m_we));
        if (e_en) begin
            chk("ram_addr", ram_addr, m_addr);
            if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
        end
        chk("if_done",   64'(if_done),   64'(e_id));
        chk("mem_done",  64'(mem_done),  64'(e_md));
        chk("if_rdata",  64'(if_rdata),  e_ir);
        chk("mem_rdata", mem_rdata,      e_mr);
        chk("stall_if",  64'(stall_if),  64'(if_req && !e_id));
        chk("stall_mem", 64'(stall_mem), 64'(mem_req && !e_md));
        if (mem_done) begin dut_seq.push_back(1'b1); last_mdone = cyc; n_mdone++; end
        else if (if_done) begin dut_seq.push_back(1'b0); last_idone = cyc; end
    endtask

    task automatic model_edge();
        bit pick_d;
        if (rst) begin
            en_cyc = -1; done_cyc = -1; free_edge = cyc + 1;
            last_d = 0; m_addr = 0; m_wdata = 0; m_we = 0;
        end else if (cyc >= free_edge && (if_req || mem_req)) begin
`ifdef ARB_RR_EN
            pick_d = mem_req && (!if_req || !last_d);
`else
            pick_d = mem_req;
`endif
            m_own_d = pick_d;
            last_d  = pick_d;
            m_addr  = pick_d ? mem_addr : if_addr;
            m_we    = pick_d && mem_we;
            if (pick_d) m_wdata = mem_wdata;
            en_cyc    = cyc + 1;
            done_cyc  = cyc + 1 + LAT;
            free_edge = cyc + LAT + 2;
        end
    endtask

    task automatic step(input bit r, input bit ir, input logic [63:0] ia,
                        input bit mr, input bit mw, input logic [63:0] ma, input logic [63:0] md);
        rst = r; if_req = ir; if_addr = ia;
        mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
        ram_rdata = {$urandom, $urandom};
        @(negedge clk);
        if (armed) check_outputs();
        @(posedge clk);
        model_edge();
        armed = 1;
        #1 cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    bit          ir, mr, mw;
    logic [63:0] ia, ma, md;
    int          t0;
    bit          e_seq[4];

    initial begin
        // Reset and reset-state values
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_addr",  ram_addr,  64'h0);
        chk("rst_wdata", ram_wdata, 64'h0);
        chk("rst_en",    64'(ram_en), 64'h0);

        // Fetch from 0x4: done at t0+3, upper word selected
        t0 = cyc;
        for (int i = 0; i < 4; i++) step(0, 1, 64'h4, 0, 0, 0, 0);
        idle(1);
        chk("fetch_lat", 64'(last_idone - t0), 64'(LAT + 1));

        // Both requesting: data first (read 0x100), fetch done at t0+7
        t0 = cyc;
        for (int i = 0; i < 8; i++) step(0, 1, 64'h0, (i < 4), 0, 64'h100, 0);
        idle(1);
        chk("both_mdone", 64'(last_mdone - t0), 64'(LAT + 1));
        chk("both_idone", 64'(last_idone - t0), 64'(2 * LAT + 3));

        // Write 0x8 / 0xDEADBEEF
        t0 = cyc;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 64'h8, 64'hDEADBEEF);
        idle(1);
        chk("wr_lat", 64'(last_mdone - t0), 64'(LAT + 1));

        // Reset in the cycle after the grant aborts the access
        n_mdone = 0;
        step(0, 0, 0, 1, 0, 64'h40, 0);
        step(1, 0, 0, 1, 0, 64'h40, 0);
        idle(4);
        chk("abort_nodone", 64'(n_mdone), 64'h0);
        t0 = cyc;
        for (int i = 0; i < 4; i++) step(0, 1, 64'h20, 0, 0, 0, 0);
        idle(1);
        chk("post_rst_fetch", 64'(last_idone - t0), 64'(LAT + 1));

        // mem_req dropped mid-access still completes exactly once
        n_mdone = 0;
        step(0, 0, 0, 1, 0, 64'h80, 0);
        step(0, 0, 0, 1, 0, 64'h80, 0);
        idle(6);
        chk("drop_once", 64'(n_mdone), 64'h1);

        // Both held continuously over four accesses after a fresh reset
        step(1, 0, 0, 0, 0, 0, 0);
        dut_seq.delete();
        for (int i = 0; i < 4 * (LAT + 2); i++) step(0, 1, 64'h0, 1, 0, 64'h200, 0);
        idle(1);
`ifdef ARB_RR_EN
        e_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        e_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("seq_len", 64'(dut_seq.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("seq_owner", 64'(dut_seq.size() > i ? dut_seq[i] : 1'bx), 64'(e_seq[i]));

        // Randomized protocol-legal traffic with occasional drops and resets
        ir = 0; mr = 0; mw = 0; ia = 0; ma = 0; md = 0;
        for (int k = 0; k < 1500; k++) begin
            if (!ir || (done_cyc == cyc - 1 && !m_own_d)) begin
                ir = ($urandom_range(2) == 0);
                ia = {$urandom, $urandom};
            end else if (!m_own_d && cyc >= en_cyc && cyc < done_cyc && $urandom_range(15) == 0) begin
                ir = 0;
            end
            if (!mr || (done_cyc == cyc - 1 && m_own_d)) begin
                mr = ($urandom_range(2) == 0);
                mw = $urandom_range(1);
                ma = {$urandom, $urandom};
                md = {$urandom, $urandom};
            end else if (m_own_d && cyc >= en_cyc && cyc < done_cyc && $urandom_range(15) == 0) begin
                mr = 0;
            end
            step(($urandom_range(49) == 0), ir, ia, mr, mw, ma, md);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
